fifo_drain_ctrl: RTL

Read-side controller for the 8-entry TLP FIFO. It issues pop strobes from the FIFO status flags and absorbs the FIFO's 1-cycle registered read latency in a 2-entry skid buffer. It presents the data downstream on a valid/ready stream and returns a pause request to the writer.
Sits between the FIFO's read port and the next TLP pipeline stage. Halts on a FIFO pointer error.

---
 rtl/tlp_fifo_pkg.sv | 24 ++
 rtl/fifo_drain_ctrl_if.sv | 24 ++
 rtl/fifo_skid_buf.sv | 57 +++++
 rtl/fifo_drain_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/tlp_fifo_pkg.sv
// -----------------------------------------------------------------------------
// tlp_fifo_pkg
// Shared definitions for the TLP FIFO read side.
//   - drain_state_e : read-controller FSM states (IDLE, RUN, HALT)
//   - FIFO_DEPTH / ALMOST_EMPTY_TH / ALMOST_FULL_TH : geometry of the TLP FIFO
//     whose registered status flags drive the read controller
//   - DEFAULT_DATA_W / DEFAULT_CNT_W / SKID_DEPTH_FIXED : default parameters
// -----------------------------------------------------------------------------
package tlp_fifo_pkg;

   localparam int FIFO_DEPTH       = 8;
   localparam int ALMOST_EMPTY_TH  = 1;  // almost_empty when occupancy <= 1
   localparam int ALMOST_FULL_TH   = 6;  // almost_full when occupancy >= 6
   localparam int DEFAULT_DATA_W   = 4;
   localparam int DEFAULT_CNT_W    = 8;
   localparam int SKID_DEPTH_FIXED = 2;  // only depth the controller supports

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } drain_state_e;

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_drain_ctrl_if
// Downstream TLP word stream leaving the FIFO read controller.
//   out_data  : stream data (DATA_W)
//   out_valid : source has a word on out_data
//   out_ready : sink can accept a word
// Handshake: a word transfers on every clock edge where out_valid && out_ready
// are both 1. Once out_valid is raised the source keeps out_valid high and
// out_data unchanged until that transfer happens; out_ready may change freely
// and never depends combinationally on out_valid.
// Modports: master = source (controller), slave = sink (next pipeline stage).
// -----------------------------------------------------------------------------
interface fifo_drain_ctrl_if
   import tlp_fifo_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
);
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fifo_skid_buf.sv
// -----------------------------------------------------------------------------
// fifo_skid_buf
// Two-entry first-in first-out buffer that catches words returned by the
// FIFO's registered read port.
//   clk, reset          : clock, synchronous active-low reset (clears contents)
//   in_valid/in_ready   : write side; a word is stored when both are 1
//   in_data             : write data
//   out_valid/out_ready : read side; head is consumed when both are 1
//   out_data            : head entry
//   count               : number of stored words (0..2)
// A write and a read in the same cycle leave count unchanged and keep order.
// -----------------------------------------------------------------------------
module fifo_skid_buf
   import tlp_fifo_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic              wr_en;
   logic              rd_en;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign out_data  = mem[rd_ptr];
   assign wr_en     = in_valid && in_ready;
   assign rd_en     = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (rd_en) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, wr_en} - {1'b0, rd_en};
      end
   end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_drain_ctrl
// Read-side controller for the 8-entry TLP FIFO. Issues pop strobes from the
// FIFO's registered status flags, absorbs the 1-cycle read latency in a
// 2-entry skid buffer and presents words on a valid/ready stream.
// Ports:
//   clk, reset           : clock, synchronous active-low reset
//   fifo_q               : FIFO read data, valid the cycle after fifo_pop
//   fifo_empty           : FIFO empty flag (registered)
//   fifo_almost_empty    : FIFO occupancy <= 1 (registered)
//   fifo_almost_full     : FIFO occupancy >= 6 (registered)
//   fifo_error           : FIFO pointer error; halts the controller
//   fifo_pop             : pop strobe to the FIFO (combinational)
//   strm                 : downstream stream (fifo_drain_ctrl_if.master)
//   pause                : registered copy of fifo_almost_full, 1 in HALT
//   halted               : sticky error indication, cleared only by reset
//   state_dbg            : current FSM state
// Optional build macro FIFO_DRAIN_STATS_EN adds saturating counters:
//   stat_pops [CNT_W]    : cycles with fifo_pop
//   stat_stalls [CNT_W]  : cycles with out_valid && !out_ready
// -----------------------------------------------------------------------------
module fifo_drain_ctrl
   import tlp_fifo_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int SKID_DEPTH = SKID_DEPTH_FIXED
`ifdef FIFO_DRAIN_STATS_EN
   ,
   parameter int CNT_W      = DEFAULT_CNT_W
`endif
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DATA_W-1:0]  fifo_q,
   input  logic               fifo_empty,
   input  logic               fifo_almost_empty,
   input  logic               fifo_almost_full,
   input  logic               fifo_error,
   output logic               fifo_pop,
   fifo_drain_ctrl_if.master  strm,
   output logic               pause,
   output logic               halted,
   output drain_state_e       state_dbg
`ifdef FIFO_DRAIN_STATS_EN
   ,
   output logic [CNT_W-1:0]   stat_pops,
   output logic [CNT_W-1:0]   stat_stalls
`endif
);

   drain_state_e      state;
   drain_state_e      state_nxt;
   logic              pop_q;
   logic [1:0]        buf_count;
   logic              head_valid;
   logic [DATA_W-1:0] head_data;
   logic              drain;
   logic [2:0]        occ_nxt;
   logic              skid_in_ready_unused;

   assign drain   = head_valid && strm.out_ready;
   // Buffer occupancy once the in-flight word (pop_q) lands and this cycle's
   // drain completes; a new pop is only safe while this stays below depth.
   assign occ_nxt = {1'b0, buf_count} + {2'b00, pop_q} - {2'b00, drain};

   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (fifo_error)       state_nxt = ST_HALT;
            else if (!fifo_empty) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (fifo_error)
               state_nxt = ST_HALT;
            else if (fifo_empty && !pop_q && (buf_count == 2'd0))
               state_nxt = ST_IDLE;
         end
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_HALT;
      endcase
      // Flags lag one pop: with almost_empty set and a pop already in flight
      // the FIFO may now be empty, so back-to-back pops are blocked. Reset
      // also masks the strobe so no word is taken while the buffer clears.
      fifo_pop = reset
              && (state != ST_HALT)
              && !fifo_empty
              && !(fifo_almost_empty && pop_q)
              && (occ_nxt < 3'(SKID_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
         pop_q <= 1'b0;
         pause <= 1'b0;
      end else begin
         state <= state_nxt;
         pop_q <= fifo_pop;
         pause <= fifo_almost_full || (state_nxt == ST_HALT);
      end
   end

   assign halted    = (state == ST_HALT);
   assign state_dbg = state;

   fifo_skid_buf #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (pop_q),
      .in_ready  (skid_in_ready_unused),
      .in_data   (fifo_q),
      .out_valid (head_valid),
      .out_ready (strm.out_ready),
      .out_data  (head_data),
      .count     (buf_count)
   );

   assign strm.out_valid = head_valid;
   assign strm.out_data  = head_data;

`ifdef FIFO_DRAIN_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         stat_pops   <= '0;
         stat_stalls <= '0;
      end else begin
         if (fifo_pop && (stat_pops != '1))
            stat_pops <= stat_pops + 1'b1;
         if (head_valid && !strm.out_ready && (stat_stalls != '1))
            stat_stalls <= stat_stalls + 1'b1;
      end
   end
`endif

endmodule
